// File: rtl/lfsr_decrypt_seq.sv
// LFSR decrypt/depad sequencer: recovers seed and taps from the preamble, then decrypts.
// Optional feature macro DECRYPT_PARITY_FLAG_EN: flag parity-corrupt bytes in bit 7.
module lfsr_decrypt_seq (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Mem_rdata,
  output logic [7:0] Mem_addr,
  output logic       Mem_wr_en,
  output logic [7:0] Mem_wdata,
  output logic       Busy,
  output logic       Ack,
  output logic       Err,
  output logic [3:0] Pat_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_DECRYPT,
    S_PAD,
    S_DONE
  } state_t;

  state_t     state_q;
  logic       start_q;
  logic [3:0] cnt_q;
  logic [3:0] pidx_q;
  logic       ok_q;
  logic [6:0] s0_q;
  logic [6:0] lfsr_q;
  logic [6:0] pre_q [10];
  logic [5:0] byte_q;
  logic       ph_q;
  logic       skip_q;
  logic [6:0] wr_ptr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       busy_q;
  logic       ack_q;
  logic       err_q;
  logic [3:0] pat_q;

  logic [6:0] tap_d;
  logic [6:0] lfsr_d;
  logic [6:0] s0_d;
  logic [6:0] plain_d;
  logic       match_d;
  logic       keep_d;
  logic       perr_d;
  logic       launch_d;
  logic       abort_d;

  function automatic logic [6:0] tap_of(input logic [3:0] i);
    logic [6:0] t;
    unique case (i)
      4'd0:    t = 7'h60;
      4'd1:    t = 7'h48;
      4'd2:    t = 7'h78;
      4'd3:    t = 7'h72;
      4'd4:    t = 7'h6A;
      4'd5:    t = 7'h69;
      4'd6:    t = 7'h5C;
      4'd7:    t = 7'h7E;
      default: t = 7'h7B;
    endcase
    return t;
  endfunction

`ifdef DECRYPT_PARITY_FLAG_EN
  assign perr_d = ^Mem_rdata;
`else
  logic unused_par;
  assign unused_par = Mem_rdata[7];
  assign perr_d     = 1'b0;
`endif

  always_comb begin
    tap_d    = tap_of(pidx_q);
    lfsr_d   = {lfsr_q[5:0], ^(lfsr_q & tap_d)};
    s0_d     = pre_q[0] ^ 7'h20;
    match_d  = ((pre_q[cnt_q] ^ lfsr_d) == 7'h20);
    plain_d  = Mem_rdata[6:0] ^ lfsr_q;
    keep_d   = !(skip_q && (plain_d == 7'h20) && !perr_d);
    launch_d = !Start && start_q;
    abort_d  = Start && (state_q != S_IDLE) && (state_q != S_DONE);
  end

  assign Mem_addr  = addr_q;
  assign Mem_wr_en = we_q;
  assign Mem_wdata = wdata_q;
  assign Busy      = busy_q;
  assign Ack       = ack_q;
  assign Err       = err_q;
  assign Pat_idx   = pat_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      pidx_q   <= '0;
      ok_q     <= 1'b0;
      s0_q     <= '0;
      lfsr_q   <= '0;
      for (int i = 0; i < 10; i++) pre_q[i] <= '0;
      byte_q   <= '0;
      ph_q     <= 1'b0;
      skip_q   <= 1'b0;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      pat_q    <= 4'hF;
    end else begin
      start_q <= Start;
      if (abort_d) begin
        state_q <= S_IDLE;
        we_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (launch_d) begin
              state_q <= S_LOAD;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              ack_q   <= 1'b0;
              err_q   <= 1'b0;
              pat_q   <= 4'hF;
            end
          end
          S_LOAD: begin
            if (cnt_q != 4'd10) addr_q <= 8'd64 + {4'b0, cnt_q};
            if (cnt_q != 4'd0) pre_q[cnt_q - 4'd1] <= Mem_rdata[6:0];
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd10) begin
              if (s0_d == 7'h00) begin
                err_q   <= 1'b1;
                ack_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                s0_q    <= s0_d;
                lfsr_q  <= s0_d;
                cnt_q   <= 4'd1;
                pidx_q  <= '0;
                ok_q    <= 1'b1;
                state_q <= S_SEARCH;
              end
            end
          end
          S_SEARCH: begin
            if (cnt_q == 4'd9) begin
              if (ok_q && match_d) begin
                pat_q    <= pidx_q;
                lfsr_q   <= s0_q;
                byte_q   <= '0;
                ph_q     <= 1'b0;
                skip_q   <= 1'b1;
                wr_ptr_q <= '0;
                state_q  <= S_DECRYPT;
              end else if (pidx_q == 4'd8) begin
                err_q   <= 1'b1;
                pat_q   <= 4'hF;
                ack_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                pidx_q <= pidx_q + 4'd1;
                cnt_q  <= 4'd1;
                ok_q   <= 1'b1;
                lfsr_q <= s0_q;
              end
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              ok_q   <= ok_q && match_d;
              lfsr_q <= lfsr_d;
            end
          end
          S_DECRYPT: begin
            if (!ph_q) begin
              addr_q <= 8'd64 + {2'b0, byte_q};
              we_q   <= 1'b0;
              ph_q   <= 1'b1;
            end else begin
              ph_q   <= 1'b0;
              lfsr_q <= lfsr_d;
              byte_q <= byte_q + 6'd1;
              if (keep_d) begin
                skip_q   <= 1'b0;
                addr_q   <= {1'b0, wr_ptr_q};
                wdata_q  <= {perr_d, plain_d};
                we_q     <= 1'b1;
                wr_ptr_q <= wr_ptr_q + 7'd1;
              end
              if (byte_q == 6'd63) state_q <= S_PAD;
            end
          end
          S_PAD: begin
            // This edge also retires the final DECRYPT write.
            if (!wr_ptr_q[6]) begin
              addr_q   <= {1'b0, wr_ptr_q};
              wdata_q  <= 8'h20;
              we_q     <= 1'b1;
              wr_ptr_q <= wr_ptr_q + 7'd1;
            end else begin
              we_q    <= 1'b0;
              ack_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            we_q <= 1'b0;
            if (Start) begin
              ack_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// Bench for lfsr_decrypt_seq: table of encrypted runs plus reset/abort sequences.
// Honours DECRYPT_PARITY_FLAG_EN for the parity vector expectations.
`timescale 1ns/1ps
module tb_lfsr_decrypt_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b1;
  logic [7:0] rdata;
  logic [7:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic       busy;
  logic       ack;
  logic       err;
  logic [3:0] pat;

  always #5 clk = ~clk;

  lfsr_decrypt_seq dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .Start    (start),
    .Mem_rdata(rdata),
    .Mem_addr (addr),
    .Mem_wr_en(we),
    .Mem_wdata(wdata),
    .Busy     (busy),
    .Ack      (ack),
    .Err      (err),
    .Pat_idx  (pat)
  );

  logic [7:0] rom  [64];
  logic [7:0] outm [64];
  logic [7:0] pt   [64];
  logic [7:0] expm [64];
  logic       clr = 1'b0;
  int         wr_cnt = 0;

  assign rdata = addr[6] ? rom[addr[5:0]] : outm[addr[5:0]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) outm[i] <= 8'hEE;
      wr_cnt <= 0;
    end else if (we) begin
      if (addr[7:6] == 2'b00) outm[addr[5:0]] <= wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    int         tap_i;
    logic [6:0] init;
    int         pre;
    int         msg;
    bit         flip;
    bit         fill;
    logic [7:0] fill_b;
    logic [3:0] exp_pat;
    logic       exp_err;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] taps [9];
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic string msg_of(input int id);
    if (id == 0) return "Mr. Watson, come here. I want to see you.";
    return " Knowledge comes, but wisdom lingers.";
  endfunction

  task automatic build(input vec_t v);
    string      m;
    int         first;
    logic [6:0] st;
    logic [6:0] c7;
    logic [6:0] tp;
    m  = msg_of(v.msg);
    tp = taps[v.tap_i][6:0];
    for (int i = 0; i < 64; i++) begin
      if (i < v.pre) pt[i] = 8'h20;
      else if (i - v.pre < m.len()) pt[i] = m[i - v.pre];
      else pt[i] = 8'h20;
    end
    st = v.init;
    for (int i = 0; i < 64; i++) begin
      c7 = pt[i][6:0] ^ st;
      rom[i] = v.fill ? v.fill_b : {^c7, c7};
      st = {st[5:0], ^(st & tp)};
    end
    if (v.flip) begin
      rom[30] = rom[30] ^ 8'h04;
      rom[40] = rom[40] ^ 8'h80;
    end
    if (v.fill) begin
      for (int j = 0; j < 64; j++) expm[j] = 8'hEE;
    end else begin
      first = 0;
      while (first < 64 && pt[first] == 8'h20) first++;
      for (int j = 0; j < 64; j++)
        expm[j] = (first + j < 64) ? pt[first + j] : 8'h20;
      if (v.flip) begin
        expm[30 - first] = expm[30 - first] ^ 8'h04;
`ifdef DECRYPT_PARITY_FLAG_EN
        expm[30 - first] = expm[30 - first] | 8'h80;
        expm[40 - first] = expm[40 - first] | 8'h80;
`endif
      end
    end
  endtask

  task automatic launch();
    clr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_mem(input string nm);
    int bad;
    int fb;
    bad = 0;
    fb = -1;
    for (int j = 0; j < 64; j++)
      if (outm[j] !== expm[j]) begin
        bad++;
        if (fb < 0) fb = j;
      end
    chk($sformatf("%s first_bad_addr=%0d bad_bytes", nm, fb), bad, 0);
  endtask

  initial begin
    bit ok;
    taps = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
    vecs[0] = '{0, 7'h01, 10, 0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0};
    vecs[1] = '{8, 7'h55, 15, 1, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0};
    vecs[2] = '{0, 7'h01, 10, 0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0};
    vecs[3] = '{0, 7'h01, 10, 0, 1'b0, 1'b1, 8'h21, 4'hF, 1'b1};
    vecs[4] = '{0, 7'h01, 10, 0, 1'b0, 1'b1, 8'h20, 4'hF, 1'b1};

    @(negedge clk);
    chk("reset_outputs", {busy, ack, err, pat, addr, we, wdata},
        {3'b000, 4'hF, 8'h00, 1'b0, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      build(vecs[k]);
      launch();
      chk($sformatf("v%0d busy_after_launch", k), busy, 1);
      wait_ack(ok);
      chk($sformatf("v%0d ack_seen", k), ok, 1);
      chk($sformatf("v%0d pat_idx", k), pat, vecs[k].exp_pat);
      chk($sformatf("v%0d err", k), err, vecs[k].exp_err);
      chk($sformatf("v%0d busy_done", k), busy, 0);
      chk($sformatf("v%0d write_count", k), wr_cnt,
          vecs[k].exp_err ? 0 : 64);
      chk_mem($sformatf("v%0d mem", k));
      start = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d ack_drop", k), ack, 0);
    end

    // Reset while DECRYPT is reading byte 20, then a clean rerun.
    build(vecs[0]);
    launch();
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (busy && addr == 8'd84) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_byte20", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, ack, err, pat, addr, we, wdata},
        {3'b000, 4'hF, 8'h00, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    launch();
    wait_ack(ok);
    chk("rerun ack_seen", ok, 1);
    chk("rerun pat_idx", pat, 0);
    chk_mem("rerun mem");
    start = 1'b1;
    @(negedge clk);

    // Abort while SEARCH is still scanning patterns.
    build(vecs[1]);
    launch();
    repeat (12) @(negedge clk);
    chk("abort busy_before", busy, 1);
    start = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort we", we, 0);
    repeat (20) @(negedge clk);
    chk("abort no_ack", ack, 0);
    chk("abort no_writes", wr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
